sseg_scan_decoder: RTL

Receive-side monitor for the multiplexed 4-digit seven-segment bus driven by the banner/display blocks. Samples the time-multiplexed anode/segment lines, waits for each digit slot to settle, and reassembles a full 4-digit frame of raw segment patterns and decoded hex values. Used in simulation scoreboards and on-chip loopback self-test, downstream of any block that drives `an`/`sseg`.

---
 rtl/sseg_scan_decoder_pkg.sv | 72 +++++++
 rtl/sseg_scan_decoder_glyph_decode.sv | 21 ++
 rtl/sseg_scan_decoder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sseg_scan_decoder_pkg.sv
// Shared seven-segment display definitions: bit order, blank anode value, active-low hex glyphs.
// Used by the banner drivers and the scan decoder.
package sseg_scan_decoder_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_A      = 0;
    localparam int SEG_G      = 6;

    localparam logic [NUM_DIGITS-1:0] AN_BLANK = 4'b1111;
    localparam logic [7:0]            SSEG_OFF = 8'hFF;

    typedef enum logic [1:0] {
        SLOT_BLANK,
        SLOT_ONE,
        SLOT_MULTI
    } slot_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HELD
    } state_e;

    typedef struct packed {
        logic [NUM_DIGITS-1:0] an;
        logic [7:0]            sseg;
    } sample_t;

    // Active-low {g,f,e,d,c,b,a} pattern for a hex value.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    function automatic slot_e classify(input logic [NUM_DIGITS-1:0] an);
        int zeros;
        zeros = 0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (!an[i]) zeros++;
        if (zeros == 0)      return SLOT_BLANK;
        else if (zeros == 1) return SLOT_ONE;
        else                 return SLOT_MULTI;
    endfunction

    // Position of the low anode; only meaningful for a SLOT_ONE sample.
    function automatic logic [1:0] digit_idx(input logic [NUM_DIGITS-1:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (!an[i]) idx = 2'(i);
        return idx;
    endfunction

endpackage

// File: rtl/sseg_scan_decoder_glyph_decode.sv
// Combinational 7-segment pattern to hex nibble lookup; ok is low for non-glyph patterns.
module sseg_glyph_decode
    import sseg_scan_decoder_pkg::*;
(
    input  logic [6:0] pat,
    output logic       ok,
    output logic [3:0] nib
);

    always_comb begin
        ok  = 1'b0;
        nib = 4'h0;
        for (int v = 0; v < 16; v++) begin
            if (pat == glyph(4'(v))) begin
                ok  = 1'b1;
                nib = 4'(v);
            end
        end
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Monitors a multiplexed 4-digit seven-segment bus, debounces each digit slot and
// reassembles complete frames of raw patterns plus decoded hex values.
module sseg_scan_decoder
    import sseg_scan_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  sseg,
    output logic [31:0] frame_seg,
    output logic [15:0] frame_hex,
    output logic [3:0]  glyph_ok,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        overlap_err,
    output logic        stale
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_C  = CW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT_CYCLES);

    logic [3:0]        an_r;
    logic [7:0]        sseg_r;
    sample_t           cur, smp_ref, smp_ref_d;
    slot_e             slot;
    state_e            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic              latch, latch_q, complete;
    logic [3:0]        seen;
    logic [3:0][7:0]   work;
    logic [3:0][3:0]   dec_hex;
    logic [3:0]        dec_ok;
    logic [TW-1:0]     tcnt;

    assign cur  = '{an: an_r, sseg: sseg_r};
    assign slot = classify(an_r);

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        smp_ref_d = smp_ref;
        latch     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (slot == SLOT_ONE) begin
                    state_d   = ST_SETTLE;
                    cnt_d     = CW'(1);
                    smp_ref_d = cur;
                end
            end
            ST_SETTLE, ST_HELD: begin
                if (slot != SLOT_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cur != smp_ref) begin
                    state_d   = ST_SETTLE;
                    cnt_d     = CW'(1);
                    smp_ref_d = cur;
                end else if (state == ST_SETTLE) begin
                    cnt_d = cnt + 1'b1;
                    if (cnt_d == STABLE_C) begin
                        latch   = 1'b1;
                        state_d = ST_HELD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Completion is checked one edge after the latch so outputs update together.
    assign complete = latch_q && (seen == 4'b1111);
    assign stale    = (tcnt == TIMEOUT_C);

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
        sseg_glyph_decode u_dec (
            .pat (work[i][SEG_G:SEG_A]),
            .ok  (dec_ok[i]),
            .nib (dec_hex[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an_r          <= AN_BLANK;
            sseg_r        <= SSEG_OFF;
            state         <= ST_IDLE;
            cnt           <= '0;
            smp_ref       <= '{an: AN_BLANK, sseg: SSEG_OFF};
            latch_q       <= 1'b0;
            seen          <= 4'b0;
            work          <= {NUM_DIGITS{SSEG_OFF}};
            frame_seg     <= 32'hFFFF_FFFF;
            frame_hex     <= 16'h0;
            glyph_ok      <= 4'h0;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            overlap_err   <= 1'b0;
            tcnt          <= '0;
        end else begin
            an_r        <= an;
            sseg_r      <= sseg;
            state       <= state_d;
            cnt         <= cnt_d;
            smp_ref     <= smp_ref_d;
            latch_q     <= latch;
            overlap_err <= (slot == SLOT_MULTI);
            if (latch)
                work[digit_idx(an_r)] <= sseg_r;
            seen          <= (complete ? 4'b0 : seen) | (latch ? ~an_r : 4'b0);
            frame_valid   <= complete;
            frame_changed <= complete && (work != frame_seg);
            if (complete) begin
                frame_seg <= work;
                frame_hex <= dec_hex;
                glyph_ok  <= dec_ok;
            end
            if (complete)
                tcnt <= '0;
            else if (tcnt != TIMEOUT_C)
                tcnt <= tcnt + 1'b1;
        end
    end

endmodule
